fifo_rd_packer: RTL and testbench

- Read-side consumer that sits directly downstream of the M:1 async FIFO read port, in the read clock domain.
- Pops WIDTH-bit entries whenever the FIFO is non-empty and packs PACK consecutive entries into one wide word.
- Presents each packed word on a valid/ready master interface.
- Flushes partial words on an idle timeout or an explicit flush request, marking valid lanes with a keep mask.

---
 rtl/fifo_rd_packer_pkg.sv | 19 +
 rtl/fifo_rd_packer_lane_reg.sv | 42 ++++
 rtl/fifo_rd_packer.sv | 181 ++++++++++++++++++
 tb/tb_fifo_rd_packer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_packer_pkg.sv
// rtl/fifo_rd_packer_pkg.sv - shared state type, lane-count width and keep-mask helper for fifo_rd_packer
package fifo_rd_packer_pkg;

  localparam int MAX_PACK = 16;
  // Lane count is sized for the largest legal PACK so every instance shares one width.
  localparam int LC_W = $clog2(MAX_PACK + 1);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  function automatic logic [MAX_PACK-1:0] keep_mask(input logic [LC_W-1:0] lc);
    logic [MAX_PACK:0] one_hot;
    one_hot = (MAX_PACK + 1)'(1) << lc;
    return MAX_PACK'(one_hot - (MAX_PACK + 1)'(1));
  endfunction

endpackage

// File: rtl/fifo_rd_packer_lane_reg.sv
// rtl/fifo_rd_packer_lane_reg.sv - lane-indexed fill register (pack_lane_reg) with write-enable and clear
module pack_lane_reg
  import fifo_rd_packer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PACK  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [LC_W-1:0]       idx_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  clr_i,
  output logic [WIDTH*PACK-1:0] fill_o
);

  logic [WIDTH*PACK-1:0] lanes_q;
  logic [WIDTH*PACK-1:0] lanes_d;

  // fill_o already includes a same-cycle write so a closing pop can be transferred on the same edge.
  always_comb begin
    lanes_d = lanes_q;
    if (we_i) begin
      for (int l = 0; l < PACK; l++) begin
        if (idx_i == LC_W'(l)) begin
          lanes_d[l*WIDTH +: WIDTH] = wdata_i;
        end
      end
    end
  end

  assign fill_o = lanes_d;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      lanes_q <= '0;
    end else begin
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs PACK FWFT FIFO entries into one valid/ready word with flush/timeout close.
// Optional FIFO_RD_PACKER_STATS_EN adds saturating accepted-word and partial-word counters.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PACK    = 4,
  parameter int TIMEOUT = 64,
  parameter int TMO_W   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_fifo_rd_en,
  input  logic                  i_fifo_empty,
  input  logic [WIDTH-1:0]      i_fifo_data,
  input  logic                  i_flush,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [WIDTH*PACK-1:0] o_m_data,
  output logic [PACK-1:0]       o_m_keep,
  output logic                  o_m_last
`ifdef FIFO_RD_PACKER_STATS_EN
  ,
  output logic [31:0]           o_stat_words,
  output logic [15:0]           o_stat_partials
`endif
);

  localparam int              DW       = WIDTH * PACK;
  localparam logic [LC_W-1:0] LC_FULL  = LC_W'(PACK);
  localparam bit              TMO_EN   = (TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  logic [LC_W-1:0]   lc_q, lc_d, lc_pop, xfer_lc;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              hold_last_q, hold_last_d;
  logic              flush_pend_q, flush_pend_d;

  logic              pop, full_close, flush_close, tmo_fire, close, slot_free;
  logic              xfer, xfer_last;
  logic [PACK-1:0]   xfer_keep;
  logic [DW-1:0]     fill_data;

  logic              m_valid_q;
  logic [DW-1:0]     m_data_q;
  logic [PACK-1:0]   m_keep_q;
  logic              m_last_q;

  pack_lane_reg #(
    .WIDTH (WIDTH),
    .PACK  (PACK)
  ) u_lanes (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .we_i    (pop),
    .idx_i   (lc_q),
    .wdata_i (i_fifo_data),
    .clr_i   (xfer),
    .fill_o  (fill_data)
  );

  always_comb begin
    pop         = (state_q == S_FILL) && !i_fifo_empty && !i_rst;
    lc_pop      = lc_q + LC_W'(pop);
    full_close  = pop && (lc_pop == LC_FULL);
    tmo_fire    = TMO_EN && (state_q == S_FILL) && !pop && (lc_q != '0) && (tmo_q == TMO_LAST);
    flush_close = (state_q == S_FILL) && i_flush && (lc_pop != '0);
    close       = full_close || flush_close || tmo_fire;
    slot_free   = !m_valid_q || i_m_ready;

    state_d      = state_q;
    lc_d         = lc_q;
    hold_last_d  = hold_last_q;
    flush_pend_d = flush_pend_q;
    xfer         = 1'b0;
    xfer_lc      = lc_q;
    xfer_last    = hold_last_q;

    unique case (state_q)
      S_FILL: begin
        lc_d = lc_pop;
        if (close) begin
          if (slot_free) begin
            xfer      = 1'b1;
            xfer_lc   = lc_pop;
            xfer_last = flush_close || tmo_fire;
            lc_d      = '0;
          end else begin
            state_d     = S_HOLD;
            hold_last_d = flush_close || tmo_fire;
          end
        end
      end
      S_HOLD: begin
        // The held fill is already closed, so a flush here only needs remembering until transfer.
        if (i_flush) begin
          flush_pend_d = 1'b1;
        end
        if (m_valid_q && i_m_ready) begin
          xfer         = 1'b1;
          lc_d         = '0;
          state_d      = S_FILL;
          flush_pend_d = 1'b0;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase

    if (!TMO_EN || pop || (lc_q == '0) || tmo_fire || (state_q != S_FILL)) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  assign xfer_keep = PACK'(keep_mask(xfer_lc));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_FILL;
      lc_q         <= '0;
      tmo_q        <= '0;
      hold_last_q  <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lc_q         <= lc_d;
      tmo_q        <= tmo_d;
      hold_last_q  <= hold_last_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else if (xfer) begin
      m_valid_q <= 1'b1;
      m_data_q  <= fill_data;
      m_keep_q  <= xfer_keep;
      m_last_q  <= xfer_last;
    end else if (i_m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign o_fifo_rd_en = pop;
  assign o_m_valid    = m_valid_q;
  assign o_m_data     = m_data_q;
  assign o_m_keep     = m_keep_q;
  assign o_m_last     = m_last_q;

`ifdef FIFO_RD_PACKER_STATS_EN
  logic [31:0] stat_words_q;
  logic [15:0] stat_partials_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stat_words_q    <= '0;
      stat_partials_q <= '0;
    end else if (m_valid_q && i_m_ready) begin
      if (stat_words_q != '1) begin
        stat_words_q <= stat_words_q + 32'd1;
      end
      if (m_last_q && (stat_partials_q != '1)) begin
        stat_partials_q <= stat_partials_q + 16'd1;
      end
    end
  end

  assign o_stat_words    = stat_words_q;
  assign o_stat_partials = stat_partials_q;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - self-checking bench for fifo_rd_packer (WIDTH=8, PACK=4, TIMEOUT=8)
module tb_fifo_rd_packer;

  localparam int WIDTH   = 8;
  localparam int PACK    = 4;
  localparam int TIMEOUT = 8;
  localparam int TMO_W   = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst, i_fifo_empty, i_flush, i_m_ready;
  logic [7:0]  i_fifo_data;
  logic        o_fifo_rd_en, o_m_valid, o_m_last;
  logic [31:0] o_m_data;
  logic [3:0]  o_m_keep;
`ifdef FIFO_RD_PACKER_STATS_EN
  logic [31:0] o_stat_words;
  logic [15:0] o_stat_partials;
`endif

  fifo_rd_packer #(
    .WIDTH (WIDTH), .PACK (PACK), .TIMEOUT (TIMEOUT), .TMO_W (TMO_W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .o_fifo_rd_en (o_fifo_rd_en),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_data  (i_fifo_data),
    .i_flush      (i_flush),
    .o_m_valid    (o_m_valid),
    .i_m_ready    (i_m_ready),
    .o_m_data     (o_m_data),
    .o_m_keep     (o_m_keep),
    .o_m_last     (o_m_last)
`ifdef FIFO_RD_PACKER_STATS_EN
    ,
    .o_stat_words    (o_stat_words),
    .o_stat_partials (o_stat_partials)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    int          c;
  } word_t;

  typedef struct {
    int          n;
    logic [31:0] b;
    int          mode;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          pops = 0;
  int          last_pop_cyc = -1;
  int          first_pop_cyc = -1;
  int          first_valid_cyc = -1;
  int          hs_viol = 0;
  bit          hide = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] pdata;
  logic [3:0]  pkeep;
  logic        plast;
  logic [7:0]  fq[$];
  word_t       wq[$];
  vec_t        vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    i_fifo_empty = (fq.size() == 0) || hide;
    i_fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    refresh();
  endtask

  task automatic tick();
    logic [7:0] dummy;
    @(negedge clk);
    if (o_fifo_rd_en) begin
      if (i_fifo_empty) begin
        chk("pop_when_empty", 1, 0);
      end else begin
        dummy = fq.pop_front();
        pops++;
        last_pop_cyc = cyc;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
    end
    if (o_m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_stall && (!o_m_valid || o_m_data !== pdata || o_m_keep !== pkeep || o_m_last !== plast))
      hs_viol++;
    prev_stall = !i_rst && o_m_valid && !i_m_ready;
    pdata = o_m_data;
    pkeep = o_m_keep;
    plast = o_m_last;
    if (o_m_valid && i_m_ready && !i_rst) wq.push_back('{o_m_data, o_m_keep, o_m_last, cyc});
    @(posedge clk);
    #1;
    cyc++;
    refresh();
  endtask

  task automatic wait_words(input int k, input int budget, input string name);
    int b = 0;
    while (wq.size() < k && b < budget) begin
      tick();
      b++;
    end
    if (wq.size() < k) chk(name, wq.size(), k);
  endtask

  task automatic check_word(input int i, input string name, input logic [31:0] d,
                            input logic [3:0] k, input logic l);
    if (i < wq.size()) begin
      chk({name, "_data"}, wq[i].data, d);
      chk({name, "_keep"}, wq[i].keep, k);
      chk({name, "_last"}, wq[i].last, l);
    end else begin
      chk({name, "_missing"}, wq.size(), i + 1);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_rd_en"}, o_fifo_rd_en, 0);
    chk({name, "_valid"}, o_m_valid, 0);
    chk({name, "_data"}, o_m_data, 0);
    chk({name, "_keep"}, o_m_keep, 0);
    chk({name, "_last"}, o_m_last, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_b[$];
    logic [7:0] got_b[$];
    int         seq, bad, viol, b;

    // mode 0: full, 1: timeout, 2: flush after pops, 3: flush with the 4th pop
    vecs[0] = '{4, 32'h14131211, 0, 32'h14131211, 4'hF, 1'b0};
    vecs[1] = '{3, 32'h00CCBBAA, 1, 32'h00CCBBAA, 4'h7, 1'b1};
    vecs[2] = '{2, 32'h00002211, 2, 32'h00002211, 4'h3, 1'b1};
    vecs[3] = '{4, 32'h34333231, 3, 32'h34333231, 4'hF, 1'b1};
    vecs[4] = '{1, 32'h0000005A, 1, 32'h0000005A, 4'h1, 1'b1};
    vecs[5] = '{3, 32'h009C9B9A, 2, 32'h009C9B9A, 4'h7, 1'b1};

    i_rst = 1'b1; i_flush = 1'b0; i_m_ready = 1'b0;
    refresh();
    repeat (3) tick();
    check_idle_outputs("reset");

    // Preloaded 01..08 with ready held high
    i_rst = 1'b0; i_m_ready = 1'b1;
    first_pop_cyc = -1; first_valid_cyc = -1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_words(2, 40, "preload_timeout");
    chk("first_valid_lat", first_valid_cyc - first_pop_cyc, 4);
    check_word(0, "preload_w0", 32'h04030201, 4'hF, 1'b0);
    check_word(1, "preload_w1", 32'h08070605, 4'hF, 1'b0);

    for (int v = 0; v < 6; v++) begin
      wq.delete();
      repeat (2) tick();
      for (int i = 0; i < vecs[v].n; i++) push(vecs[v].b[i*8 +: 8]);
      if (vecs[v].mode == 2) begin
        repeat (vecs[v].n + 1) tick();
        i_flush = 1'b1; tick(); i_flush = 1'b0;
      end else if (vecs[v].mode == 3) begin
        repeat (3) tick();
        i_flush = 1'b1; tick(); i_flush = 1'b0;
      end
      wait_words(1, 40, $sformatf("vec%0d_timeout", v));
      check_word(0, $sformatf("vec%0d", v), vecs[v].ed, vecs[v].ek, vecs[v].el);
      if (vecs[v].mode == 1 && wq.size() > 0)
        chk($sformatf("vec%0d_tmo_lat", v), wq[0].c - last_pop_cyc, TIMEOUT + 1);
      repeat (TIMEOUT + 4) tick();
      chk($sformatf("vec%0d_count", v), wq.size(), 1);
    end

    // Flush with nothing buffered
    wq.delete();
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    repeat (TIMEOUT + 4) tick();
    chk("flush_empty_words", wq.size(), 0);
    chk("flush_empty_valid", o_m_valid, 0);

    // Backpressure: 12 queued, ready low
    wq.delete(); pops = 0; i_m_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(8'h40 + 8'(i));
    repeat (20) tick();
    chk("hold_pops", pops, 8);
    chk("hold_rd_en", o_fifo_rd_en, 0);
    chk("hold_valid", o_m_valid, 1);
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    repeat (3) tick();
    i_m_ready = 1'b1;
    wait_words(3, 60, "hold_timeout");
    check_word(0, "hold_w0", 32'h43424140, 4'hF, 1'b0);
    check_word(1, "hold_w1", 32'h47464544, 4'hF, 1'b0);
    check_word(2, "hold_w2", 32'h4B4A4948, 4'hF, 1'b0);
    repeat (TIMEOUT + 4) tick();
    chk("hold_count", wq.size(), 3);

    // Reset with lc=2 and a word waiting in the output register
    wq.delete(); i_m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
    repeat (8) tick();
    chk("pre_rst_valid", o_m_valid, 1);
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    check_idle_outputs("mid_rst");
    i_m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h70 + 8'(i));
    wait_words(1, 40, "post_rst_timeout");
    check_word(0, "post_rst", 32'h73727170, 4'hF, 1'b0);
    repeat (TIMEOUT + 4) tick();
    chk("post_rst_count", wq.size(), 1);

    // Random traffic: two writers, random gaps, random ready and flush
    wq.delete(); seq = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int w = 0; w < 2; w++) begin
        if ($urandom_range(0, 3) == 0) begin
          push(8'(seq));
          exp_b.push_back(8'(seq));
          seq++;
        end
      end
      hide = ($urandom_range(0, 4) == 0);
      refresh();
      i_m_ready = ($urandom_range(0, 2) != 0);
      i_flush   = ($urandom_range(0, 29) == 0);
      tick();
    end
    i_flush = 1'b0; hide = 1'b0; i_m_ready = 1'b1;
    refresh();
    b = 0;
    while (fq.size() != 0 && b < 2000) begin
      tick();
      b++;
    end
    repeat (TIMEOUT + 10) tick();

    bad = 0; viol = 0;
    foreach (wq[i]) begin
      if (!(wq[i].keep inside {4'h1, 4'h3, 4'h7, 4'hF})) viol++;
      if (wq[i].keep != 4'hF && !wq[i].last) viol++;
      for (int l = 0; l < PACK; l++) begin
        if (wq[i].keep[l]) got_b.push_back(wq[i].data[l*8 +: 8]);
        else if (wq[i].data[l*8 +: 8] != 8'h00) viol++;
      end
    end
    foreach (exp_b[i]) begin
      if (i >= got_b.size() || got_b[i] !== exp_b[i]) bad++;
    end
    chk("rand_fifo_drained", fq.size(), 0);
    chk("rand_len", got_b.size(), exp_b.size());
    chk("rand_bytes", bad, 0);
    chk("rand_word_rules", viol, 0);
    chk("handshake_stable", hs_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
